// File: rtl/anton_neopixel_sequencer_pkg.sv
// Shared types and defaults for the NeoPixel timing sequencer.
// Imported by the sequencer top and its reset timer.
package anton_neopixel_sequencer_pkg;

  localparam int unsigned BUFFER_END_DEFAULT  = 255;
  localparam int unsigned RESET_DELAY_DEFAULT = 400;

  typedef enum logic {
    ST_RESET    = 1'b0,
    ST_TRANSMIT = 1'b1
  } seq_state_e;

  localparam logic [2:0] SLOT_LAST = 3'd7;
  localparam logic [4:0] BIT_LAST  = 5'd23;

endpackage

// File: rtl/anton_reset_timer.sv
// Saturating latch-period counter: counts 0..RESET_DELAY-1 and holds.
// done is high while the counter sits at its saturated value.
module anton_reset_timer
  import anton_neopixel_sequencer_pkg::*;
#(
  parameter int unsigned RESET_DELAY = RESET_DELAY_DEFAULT
) (
  input  logic clk7mhz,
  input  logic rstn,
  input  logic clear,
  output logic done
);

  localparam int unsigned CW =
    (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RESET_DELAY - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_MAX);

endmodule

// File: rtl/anton_neopixel_sequencer.sv
// Walks pixel/bit/slot indices for the NeoPixel serialiser and
// times the latch (RESET) gap between frames.
module anton_neopixel_sequencer
  import anton_neopixel_sequencer_pkg::*;
#(
  parameter int unsigned  BUFFER_END  = BUFFER_END_DEFAULT,
  parameter int unsigned  RESET_DELAY = RESET_DELAY_DEFAULT,
  localparam int unsigned BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   rstn,
  input  logic                   regCtrlRun,
  input  logic                   regCtrlLoop,
  input  logic                   regCtrlInit,
  input  logic                   regCtrl32bit,
  input  logic [BUFFER_BITS-1:0] regMax,
  output logic                   state,
  output logic [BUFFER_BITS-1:0] pixelIndex,
  output logic [4:0]             pixelBitIndex,
  output logic [2:0]             bitPatternIndex,
  output logic                   frameDone,
  output logic                   busy
);

  localparam int unsigned BB = BUFFER_BITS;
  localparam logic [BB:0] END_EXT  = (BB+1)'(BUFFER_END);
  localparam logic [BB:0] PIX_ONE  = (BB+1)'(1);
  localparam logic [BB:0] PIX_FOUR = (BB+1)'(4);

  seq_state_e    state_q;
  seq_state_e    state_d;
  logic [BB-1:0] pix_q;
  logic [BB-1:0] pix_d;
  logic [4:0]    bit_q;
  logic [4:0]    bit_d;
  logic [2:0]    slot_q;
  logic [2:0]    slot_d;
  logic [BB-1:0] max_q;
  logic [BB-1:0] max_d;
  logic          wide_q;
  logic          wide_d;
  logic          pending_q;
  logic          pending_d;
  logic          busy_q;
  logic          busy_d;
  logic          frame_done_q;
  logic          frame_done_d;

  logic          timer_clear;
  logic          timer_done;
  logic          in_tx;
  logic          last_slot;
  logic          last_bit;
  logic          last_pix;
  logic          pix_ovf;
  logic          start;
  logic          frame_end;
  logic          tx_step;
  logic [BB:0]   pix_next;
  logic [BB-1:0] max_clamped;

  always_comb begin
    in_tx     = (state_q == ST_TRANSMIT);
    last_slot = (slot_q == SLOT_LAST);
    last_bit  = (bit_q == BIT_LAST);

    if (wide_q) begin
      pix_next = {1'b0, pix_q[BB-1:2], 2'b00} + PIX_FOUR;
    end else begin
      pix_next = {1'b0, pix_q} + PIX_ONE;
    end
    // A step past the buffer end ends the frame instead of wrapping.
    pix_ovf = (pix_next > END_EXT);

    if (wide_q) begin
      last_pix = (pix_q[BB-1:2] == max_q[BB-1:2]);
    end else begin
      last_pix = (pix_q == max_q);
    end

    if ({1'b0, regMax} > END_EXT) begin
      max_clamped = END_EXT[BB-1:0];
    end else begin
      max_clamped = regMax;
    end

    start = regCtrlRun && !in_tx && timer_done &&
            (regCtrlLoop || pending_q);
    frame_end = regCtrlRun && in_tx && last_slot &&
                last_bit && (last_pix || pix_ovf);
    tx_step = regCtrlRun && in_tx && !frame_end;

    timer_clear = !regCtrlRun || start || in_tx;
  end

  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    bit_d        = bit_q;
    slot_d       = slot_q;
    max_d        = max_q;
    wide_d       = wide_q;
    pending_d    = pending_q | regCtrlInit;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    unique case (1'b1)
      !regCtrlRun: begin
        state_d   = ST_RESET;
        pix_d     = '0;
        bit_d     = '0;
        slot_d    = '0;
        pending_d = 1'b0;
        busy_d    = 1'b0;
      end
      start: begin
        state_d   = ST_TRANSMIT;
        pix_d     = '0;
        bit_d     = '0;
        slot_d    = '0;
        wide_d    = regCtrl32bit;
        max_d     = max_clamped;
        pending_d = regCtrlInit;
        busy_d    = 1'b1;
      end
      frame_end: begin
        state_d      = ST_RESET;
        pix_d        = '0;
        bit_d        = '0;
        slot_d       = '0;
        busy_d       = 1'b1;
        frame_done_d = 1'b1;
      end
      tx_step: begin
        slot_d = slot_q + 3'd1;
        busy_d = 1'b1;
        if (last_slot) begin
          bit_d = last_bit ? 5'd0 : bit_q + 5'd1;
          if (last_bit) begin
            pix_d = pix_next[BB-1:0];
          end
        end
      end
      default: begin
        // Idle in RESET: busy ends with the latch period.
        busy_d = busy_q & ~timer_done;
      end
    endcase
  end

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_RESET;
      pix_q        <= '0;
      bit_q        <= '0;
      slot_q       <= '0;
      max_q        <= '0;
      wide_q       <= 1'b0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      bit_q        <= bit_d;
      slot_q       <= slot_d;
      max_q        <= max_d;
      wide_q       <= wide_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  anton_reset_timer #(
    .RESET_DELAY(RESET_DELAY)
  ) u_reset_timer (
    .clk7mhz(clk7mhz),
    .rstn   (rstn),
    .clear  (timer_clear),
    .done   (timer_done)
  );

  assign state           = state_q;
  assign pixelIndex      = pix_q;
  assign pixelBitIndex   = bit_q;
  assign bitPatternIndex = slot_q;
  assign frameDone       = frame_done_q;
  assign busy            = busy_q;

endmodule
